// File: rtl/fsm_seq_pkg.sv
// Shared constants and default parameters for the sequence counter.
package fsm_seq_pkg;

  // Step direction encodings for the dir input.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Defaults reproduce the classic 000->100->111->010->011 lab counter.
  localparam int unsigned DefWidth = 3;
  localparam int unsigned DefDepth = 5;
  localparam logic [DefDepth*DefWidth-1:0] DefSeqInit =
      {3'b011, 3'b010, 3'b111, 3'b100, 3'b000};

endpackage

// File: rtl/fsm_seq_counter_if.sv
// Control/status bundle of the sequence counter; master drives controls, slave is the counter.
interface fsm_seq_counter_if
  import fsm_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned IW    = $clog2(DEPTH)
);

  logic             en;
  logic             dir;
  logic             load;
  logic [IW-1:0]    load_idx;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] count;
  logic [IW-1:0]    idx;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, load, load_idx, wr_en, wr_idx, wr_val,
    input  count, idx, wrap, err
  );

  modport slave (
    input  en, dir, load, load_idx, wr_en, wr_idx, wr_val,
    output count, idx, wrap, err
  );

endinterface

// File: rtl/seq_table.sv
// Register file holding the code table: one range-checked write port, one combinational read port.
module seq_table
  import fsm_seq_pkg::*;
#(
  parameter int unsigned             WIDTH    = DefWidth,
  parameter int unsigned             DEPTH    = DefDepth,
  parameter int unsigned             IW       = $clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0]  SEQ_INIT = DefSeqInit
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_val_i,
  output logic             wr_err_o,
  input  logic [IW-1:0]    rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        wr_ok;

  // Apply an in-range write; flag and drop an out-of-range one.
  always_comb begin
    wr_ok    = 32'(wr_idx_i) < DEPTH;
    wr_err_o = wr_en_i & ~wr_ok;
    mem_d    = mem_q;
    if (wr_en_i && wr_ok) begin
      mem_d[wr_idx_i] = wr_val_i;
    end
  end

  // Table registers; reset restores the initial sequence and discards all writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= SEQ_INIT;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port; the guard only matters for index encodings beyond DEPTH-1.
  always_comb begin
    rd_data_o = '0;
    if (32'(rd_idx_i) < DEPTH) begin
      rd_data_o = mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/fsm_seq_counter.sv
// Programmable sequence counter: index register with load/step priority, registered wrap/err.
module fsm_seq_counter
  import fsm_seq_pkg::*;
#(
  parameter int unsigned             WIDTH    = DefWidth,
  parameter int unsigned             DEPTH    = DefDepth,
  parameter int unsigned             IW       = $clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0]  SEQ_INIT = DefSeqInit
) (
  input  logic               clk,
  input  logic               rst_n,
  fsm_seq_counter_if.slave   bus
);

  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  logic [IW-1:0]    idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             bad_load;
  logic             wr_err;
  logic [WIDTH-1:0] rd_data;

  seq_table #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .IW       (IW),
    .SEQ_INIT (SEQ_INIT)
  ) u_table (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_idx_i  (bus.wr_idx),
    .wr_val_i  (bus.wr_val),
    .wr_err_o  (wr_err),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  // Next index: load beats step; load never raises wrap, even across the table end.
  always_comb begin
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    bad_load = 1'b0;
    if (bus.load) begin
      if (32'(bus.load_idx) < DEPTH) begin
        idx_d = bus.load_idx;
      end else begin
        idx_d    = '0;
        bad_load = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.dir == DIR_FWD) begin
        if (idx_q == LastIdx) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = LastIdx;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
    end
    err_d = bad_load | wr_err;
  end

  // Index and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Outputs come straight from registers, so count moves only on an edge or reset.
  always_comb begin
    bus.count = rd_data;
    bus.idx   = idx_q;
    bus.wrap  = wrap_q;
    bus.err   = err_q;
  end

endmodule
